// File: rtl/vj_window_scheduler_if.sv
// ---------------------------------------------------------------------------
// vj_window_scheduler_if
// Groups the channels between the window scheduler and the Viola-Jones
// classifier pipeline.
//   win_*  : window coordinate offer (valid/ready handshake)
//   res_*  : in-order verdicts coming back from the pipeline (no backpressure)
//   det_*  : detection pulses leaving the scheduler (no backpressure)
// Modports:
//   master : the scheduler side
//   slave  : the pipeline / consumer side
// ---------------------------------------------------------------------------
interface vj_window_scheduler_if #(
   parameter int COORD_W = 9
);
   logic               win_valid;
   logic               win_ready;
   logic [COORD_W-1:0] win_x;
   logic [COORD_W-1:0] win_y;
   logic               res_valid;
   logic               res_face;
   logic               det_valid;
   logic [COORD_W-1:0] det_x;
   logic [COORD_W-1:0] det_y;

   modport master (
      output win_valid, win_x, win_y, det_valid, det_x, det_y,
      input  win_ready, res_valid, res_face
   );

   modport slave (
      input  win_valid, win_x, win_y, det_valid, det_x, det_y,
      output win_ready, res_valid, res_face
   );
endinterface

// File: rtl/vj_window_scheduler.sv
// ---------------------------------------------------------------------------
// vj_window_scheduler
// Walks scan-window positions across one integral-image frame in raster order,
// offers them to the classifier pipeline, remembers in-flight coordinates in a
// FIFO (verdicts return in order but untagged) and reports face detections.
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   start          : one-cycle pulse that begins a frame scan (IDLE only)
//   busy           : high while scanning or draining
//   done           : one-cycle pulse once the frame is scanned and drained
//   bus            : vj_window_scheduler_if.master (win_*, res_*, det_*)
//   det_count      : faces found this frame, saturating at 16'hFFFF
//   err_underflow  : sticky, a verdict arrived with no window in flight
//
// Optional build macro VJ_SCHED_PERF_EN adds:
//   perf_cycles    : busy cycles of the last frame
//   perf_stalls    : SCAN cycles with an unaccepted offer or a full FIFO
// ---------------------------------------------------------------------------
module vj_window_scheduler #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int WIN_SIZE   = 24,
   parameter int STEP       = 1,
   parameter int PIPE_DEPTH = 16,
   parameter int COORD_W    = 9
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   vj_window_scheduler_if.master        bus,
   output logic [15:0]                  det_count,
   output logic                         err_underflow
`ifdef VJ_SCHED_PERF_EN
   ,
   output logic [31:0]                  perf_cycles,
   output logic [31:0]                  perf_stalls
`endif
);

   localparam int X_MAX = IMG_WIDTH - WIN_SIZE;
   localparam int Y_MAX = IMG_HEIGHT - WIN_SIZE;
   localparam int PTR_W = $clog2(PIPE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   generate
      if (IMG_WIDTH < WIN_SIZE || IMG_HEIGHT < WIN_SIZE) begin : g_bad_geometry
         $error("vj_window_scheduler: frame smaller than scan window");
      end
      if (PIPE_DEPTH < 2 || (PIPE_DEPTH & (PIPE_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("vj_window_scheduler: PIPE_DEPTH must be a power of two >= 2");
      end
      if (STEP < 1) begin : g_bad_step
         $error("vj_window_scheduler: STEP must be at least 1");
      end
      if (X_MAX >= (1 << COORD_W) || Y_MAX >= (1 << COORD_W)) begin : g_bad_coord
         $error("vj_window_scheduler: COORD_W too narrow for frame");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [COORD_W-1:0]   x_q, x_d;
   logic [COORD_W-1:0]   y_q, y_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 det_valid_q, det_valid_d;
   logic [COORD_W-1:0]   det_x_q, det_x_d;
   logic [COORD_W-1:0]   det_y_q, det_y_d;
   logic [15:0]          det_count_q, det_count_d;
   logic                 err_q, err_d;

   // Coordinate storage carries no reset; only occupancy/pointers matter.
   logic [2*COORD_W-1:0] fifo_mem [PIPE_DEPTH];
   logic [COORD_W-1:0]   head_x, head_y;

   logic fifo_full, fifo_empty, win_valid, push, pop, underflow;
   logic last_x, last_y;

   assign fifo_full  = (count_q == CNT_W'(PIPE_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign win_valid  = (state_q == ST_SCAN) && !fifo_full;
   assign push       = win_valid && bus.win_ready;
   assign pop        = bus.res_valid && (state_q != ST_IDLE) && !fifo_empty;
   assign underflow  = bus.res_valid && fifo_empty;
   assign last_x     = (int'(x_q) + STEP > X_MAX);
   assign last_y     = (int'(y_q) + STEP > Y_MAX);
   assign {head_x, head_y} = fifo_mem[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {x_q, y_q};
      end
   end

   // FIFO bookkeeping; occupancy is untouched when push and pop coincide.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Scan sequencing and verdict handling.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      det_valid_d = pop && bus.res_face;
      det_x_d     = det_x_q;
      det_y_d     = det_y_q;
      det_count_d = det_count_q;
      err_d       = err_q | underflow;

      if (pop && bus.res_face) begin
         det_x_d = head_x;
         det_y_d = head_y;
         if (det_count_q != 16'hFFFF) begin
            det_count_d = det_count_q + 16'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_SCAN;
               x_d         = '0;
               y_d         = '0;
               det_count_d = '0;
               err_d       = 1'b0;
            end
         end
         ST_SCAN: begin
            if (push) begin
               if (!last_x) begin
                  x_d = x_q + COORD_W'(STEP);
               end else if (!last_y) begin
                  x_d = '0;
                  y_d = y_q + COORD_W'(STEP);
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Entered only from SCAN, so DRAIN always lasts at least one cycle.
            if (count_d == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         det_valid_q <= 1'b0;
         det_x_q     <= '0;
         det_y_q     <= '0;
         det_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         det_valid_q <= det_valid_d;
         det_x_q     <= det_x_d;
         det_y_q     <= det_y_d;
         det_count_q <= det_count_d;
         err_q       <= err_d;
      end
   end

   assign busy          = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign done          = (state_q == ST_DONE);
   assign bus.win_valid = win_valid;
   assign bus.win_x     = x_q;
   assign bus.win_y     = y_q;
   assign bus.det_valid = det_valid_q;
   assign bus.det_x     = det_x_q;
   assign bus.det_y     = det_y_q;
   assign det_count     = det_count_q;
   assign err_underflow = err_q;

`ifdef VJ_SCHED_PERF_EN
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [31:0] perf_stalls_q, perf_stalls_d;

   // Counters restart on an accepted start and freeze once the frame ends.
   always_comb begin
      perf_cycles_d = perf_cycles_q;
      perf_stalls_d = perf_stalls_q;
      if (state_q == ST_IDLE && start) begin
         perf_cycles_d = '0;
         perf_stalls_d = '0;
      end else begin
         if (busy) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
         end
         if (state_q == ST_SCAN && ((win_valid && !bus.win_ready) || fifo_full)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_vj_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vj_window_scheduler
// Directed bench for vj_window_scheduler on a 26x26 frame with a 24x24
// window (3x3 = 9 positions, raster order) and a 4-entry coordinate FIFO.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vj_window_scheduler;

   localparam int COORD_W = 9;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        err_underflow;
   logic [15:0] det_count;

   int checks = 0;
   int errors = 0;

   vj_window_scheduler_if #(.COORD_W(COORD_W)) bus ();

`ifdef VJ_SCHED_PERF_EN
   logic [31:0] perf_cycles;
   logic [31:0] perf_stalls;
`endif

   vj_window_scheduler #(
      .IMG_WIDTH  (26),
      .IMG_HEIGHT (26),
      .WIN_SIZE   (24),
      .STEP       (1),
      .PIPE_DEPTH (4),
      .COORD_W    (COORD_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .bus           (bus),
      .det_count     (det_count),
      .err_underflow (err_underflow)
`ifdef VJ_SCHED_PERF_EN
      ,
      .perf_cycles   (perf_cycles),
      .perf_stalls   (perf_stalls)
`endif
   );

   always #5 clock = ~clock;

   // Leaves the caller on the falling edge right after start was taken.
   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      bus.win_ready = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_face  = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({busy, done, bus.win_valid, bus.det_valid, err_underflow} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b want 00000",
                  {busy, done, bus.win_valid, bus.det_valid, err_underflow});
      end
      checks++;
      if (bus.win_x !== 9'd0 || bus.win_y !== 9'd0) begin
         errors++;
         $display("[TB] FAIL reset_win_xy: got %0d,%0d want 0,0", bus.win_x, bus.win_y);
      end
      checks++;
      if (bus.det_x !== 9'd0 || bus.det_y !== 9'd0 || det_count !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_det: got %0d,%0d cnt %0d want 0,0 cnt 0",
                  bus.det_x, bus.det_y, det_count);
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || bus.win_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got busy %b win_valid %b want 0 0",
                  busy, bus.win_valid);
      end
   endtask

   // One full frame with verdicts returned 3 cycles after issue. Window
   // (fx,fy) is the only face; stall_mode drives win_ready as 1,0,0,1,...
   task automatic test_scan_frame(input string name, input bit stall_mode,
                                  input int fx, input int fy);
      int       issued;
      int       popped;
      int       dets;
      int       dones;
      int       exp_dets;
      logic [2:0] pipe;
      logic [3:0] ready_pat;
      bit       finished;
      bit       hs;
      issued    = 0;
      popped    = 0;
      dets      = 0;
      dones     = 0;
      pipe      = 3'b000;
      ready_pat = 4'b1001;
      finished  = 1'b0;
      exp_dets  = (fx >= 0 && fx <= 2 && fy >= 0 && fy <= 2) ? 1 : 0;
      bus.win_ready = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_face  = 1'b0;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         if (cyc != 0) @(negedge clock);
         if (bus.det_valid === 1'b1) begin
            dets++;
            checks++;
            if (int'(bus.det_x) != fx || int'(bus.det_y) != fy) begin
               errors++;
               $display("[TB] FAIL %s det_xy: got %0d,%0d want %0d,%0d",
                        name, bus.det_x, bus.det_y, fx, fy);
            end
         end
         if (done === 1'b1) begin
            dones++;
            finished = 1'b1;
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("[TB] FAIL %s busy_at_done: got %b want 0", name, busy);
            end
         end
         if (bus.win_valid === 1'b1) begin
            checks++;
            if (issued >= 9) begin
               errors++;
               $display("[TB] FAIL %s extra_window: got %0d,%0d want no offer",
                        name, bus.win_x, bus.win_y);
            end else if (int'(bus.win_x) != issued % 3 || int'(bus.win_y) != issued / 3) begin
               errors++;
               $display("[TB] FAIL %s win_xy[%0d]: got %0d,%0d want %0d,%0d",
                        name, issued, bus.win_x, bus.win_y, issued % 3, issued / 3);
            end
         end
         bus.win_ready = stall_mode ? ready_pat[cyc % 4] : 1'b1;
         hs = (bus.win_valid === 1'b1) && bus.win_ready;
         if (hs) issued++;
         bus.res_valid = pipe[2];
         bus.res_face  = 1'b0;
         if (pipe[2]) begin
            bus.res_face = (popped % 3 == fx) && (popped / 3 == fy);
            popped++;
         end
         pipe = {pipe[1:0], hs};
      end
      bus.win_ready = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_face  = 1'b0;
      checks++;
      if (!finished) begin
         errors++;
         $display("[TB] FAIL %s timeout: got no done want done within 300 cycles", name);
      end
      repeat (3) begin
         @(negedge clock);
         if (done === 1'b1) dones++;
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("[TB] FAIL %s done_pulses: got %0d want 1", name, dones);
      end
      checks++;
      if (issued != 9) begin
         errors++;
         $display("[TB] FAIL %s issued: got %0d want 9", name, issued);
      end
      checks++;
      if (dets != exp_dets) begin
         errors++;
         $display("[TB] FAIL %s det_pulses: got %0d want %0d", name, dets, exp_dets);
      end
      checks++;
      if (det_count !== 16'(exp_dets)) begin
         errors++;
         $display("[TB] FAIL %s det_count: got %0d want %0d", name, det_count, exp_dets);
      end
   endtask

   // FIFO fills to 4 with verdicts withheld; one verdict lets exactly one
   // more window out; then all verdicts (faces) drain the frame.
   task automatic test_backpressure();
      int issued;
      int outstanding;
      int popped;
      int dets;
      int idx;
      int exp_det[$];
      bit finished;
      issued      = 0;
      outstanding = 0;
      popped      = 0;
      dets        = 0;
      finished    = 1'b0;
      pulse_start();
      bus.win_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc != 0) @(negedge clock);
         if (bus.win_valid === 1'b1) begin
            issued++;
            outstanding++;
         end
      end
      @(negedge clock);
      checks++;
      if (issued != 4 || bus.win_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_fill: got issued %0d win_valid %b want 4 0",
                  issued, bus.win_valid);
      end
      bus.res_valid = 1'b1;
      bus.res_face  = 1'b0;
      popped++;
      outstanding--;
      @(negedge clock);
      bus.res_valid = 1'b0;
      checks++;
      if (bus.det_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_nonface_det: got %b want 0", bus.det_valid);
      end
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc != 0) @(negedge clock);
         if (bus.win_valid === 1'b1) begin
            issued++;
            outstanding++;
         end
      end
      @(negedge clock);
      checks++;
      if (issued != 5 || bus.win_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_one_more: got issued %0d win_valid %b want 5 0",
                  issued, bus.win_valid);
      end
      for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
         if (cyc != 0) @(negedge clock);
         if (bus.det_valid === 1'b1) begin
            dets++;
            checks++;
            if (exp_det.size() == 0) begin
               errors++;
               $display("[TB] FAIL bp_det_extra: got %0d,%0d want none", bus.det_x, bus.det_y);
            end else begin
               idx = exp_det.pop_front();
               if (int'(bus.det_x) != idx % 3 || int'(bus.det_y) != idx / 3) begin
                  errors++;
                  $display("[TB] FAIL bp_det_xy: got %0d,%0d want %0d,%0d",
                           bus.det_x, bus.det_y, idx % 3, idx / 3);
               end
            end
         end
         if (done === 1'b1) finished = 1'b1;
         bus.res_valid = (outstanding > 0) && !finished;
         bus.res_face  = 1'b1;
         if (bus.res_valid) begin
            exp_det.push_back(popped);
            popped++;
            outstanding--;
         end
         if (bus.win_valid === 1'b1) begin
            issued++;
            outstanding++;
         end
      end
      bus.res_valid = 1'b0;
      bus.res_face  = 1'b0;
      bus.win_ready = 1'b0;
      checks++;
      if (!finished) begin
         errors++;
         $display("[TB] FAIL bp_timeout: got no done want done within 100 cycles");
      end
      checks++;
      if (issued != 9 || dets != 8 || exp_det.size() != 0) begin
         errors++;
         $display("[TB] FAIL bp_totals: got issued %0d dets %0d left %0d want 9 8 0",
                  issued, dets, exp_det.size());
      end
      checks++;
      if (det_count !== 16'd8) begin
         errors++;
         $display("[TB] FAIL bp_det_count: got %0d want 8", det_count);
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_underflow();
      @(negedge clock);
      bus.res_valid = 1'b1;
      bus.res_face  = 1'b1;
      @(negedge clock);
      bus.res_valid = 1'b0;
      bus.res_face  = 1'b0;
      checks++;
      if (err_underflow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL underflow_set: got %b want 1", err_underflow);
      end
      checks++;
      if (bus.det_valid !== 1'b0 || det_count !== 16'd0) begin
         errors++;
         $display("[TB] FAIL underflow_no_det: got %b cnt %0d want 0 cnt 0",
                  bus.det_valid, det_count);
      end
      @(negedge clock);
      checks++;
      if (err_underflow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL underflow_sticky: got %b want 1", err_underflow);
      end
      pulse_start();
      checks++;
      if (err_underflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL underflow_clear_on_start: got %b want 0", err_underflow);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_scan();
      int issued;
      int outstanding;
      int dones;
      issued      = 0;
      outstanding = 0;
      dones       = 0;
      pulse_start();
      bus.win_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && issued < 5; cyc++) begin
         if (cyc != 0) @(negedge clock);
         bus.res_valid = (outstanding > 0);
         bus.res_face  = 1'b1;
         if (outstanding > 0) outstanding--;
         if (bus.win_valid === 1'b1) begin
            issued++;
            outstanding++;
         end
      end
      checks++;
      if (issued != 5) begin
         errors++;
         $display("[TB] FAIL midscan_issue: got %0d want 5", issued);
      end
      @(posedge clock);
      #1;
      checks++;
      if (bus.win_x !== 9'd2 || bus.win_y !== 9'd1 || det_count !== 16'd4) begin
         errors++;
         $display("[TB] FAIL midscan_progress: got %0d,%0d cnt %0d want 2,1 cnt 4",
                  bus.win_x, bus.win_y, det_count);
      end
      #1;
      reset = 1'b1;
      bus.win_ready = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_face  = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.win_valid, bus.det_valid, err_underflow} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL midscan_reset_flags: got %b want 00000",
                  {busy, done, bus.win_valid, bus.det_valid, err_underflow});
      end
      checks++;
      if (bus.win_x !== 9'd0 || bus.win_y !== 9'd0 || bus.det_x !== 9'd0 ||
          bus.det_y !== 9'd0 || det_count !== 16'd0) begin
         errors++;
         $display("[TB] FAIL midscan_reset_values: got win %0d,%0d det %0d,%0d cnt %0d want zeros",
                  bus.win_x, bus.win_y, bus.det_x, bus.det_y, det_count);
      end
      repeat (3) begin
         @(negedge clock);
         if (done === 1'b1) dones++;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (done === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("[TB] FAIL midscan_no_done: got %0d pulses want 0", dones);
      end
   endtask

   initial begin
      test_reset();
      test_scan_frame("raster", 1'b0, -1, -1);
      test_scan_frame("one_face", 1'b0, 1, 1);
      test_backpressure();
      test_scan_frame("ready_stall", 1'b1, -1, -1);
      test_underflow();
      test_reset_mid_scan();
      test_scan_frame("rescan", 1'b0, 2, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
